batch_dispatch_arbiter: RTL and testbench

- Shares one downstream executor port between NUM_PARALLEL_INSTANCES batcher output streams.
- Round-robin arbitration with batch atomicity: a grant is held from the first beat to the last beat of a batch.
- Tracks outstanding (dispatched, not yet retired) batches per instance and throttles each instance at MAX_OUTSTANDING.
- Converts executor completion reports into per-instance batch_retire pulses, which feed the conflict manager's batch-completion input.

---
 rtl/sched_pkg.sv | 19 +
 rtl/batch_dispatch_arbiter_rr_pick.sv | 34 +++
 rtl/batch_dispatch_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_batch_dispatch_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sched_pkg.sv
// Shared scheduler types: instance index, dependency vector, and dispatch FSM states.
package sched_pkg;

    localparam int unsigned SCHED_NUM_INST = 4;
    localparam int unsigned SCHED_MAX_DEPS = 256;
    localparam int unsigned SCHED_IDX_W    = $clog2(SCHED_NUM_INST);
    localparam int unsigned OWNER_W        = 64;
    localparam int unsigned OCNT_W         = 4;
    localparam int unsigned STAT_W         = 32;

    typedef logic [SCHED_IDX_W-1:0]    inst_idx_t;
    typedef logic [SCHED_MAX_DEPS-1:0] dep_vec_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

endpackage

// File: rtl/batch_dispatch_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set request at or after ptr, wrapping.
module rr_pick #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx
);

    int unsigned      sum;
    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        sum       = 0;
        cand      = '0;
        for (int unsigned off = 0; off < N; off++) begin
            // ptr < N and off < N, so one conditional subtract is a full modulo
            sum = 32'(ptr) + off;
            if (sum >= N) begin
                sum = sum - N;
            end
            cand = IDX_W'(sum);
            if (!gnt_valid && req[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/batch_dispatch_arbiter.sv
// Shares one executor port among batcher streams with batch-atomic round-robin grants,
// per-instance outstanding-batch throttling and completion-to-retire pulse conversion.
module batch_dispatch_arbiter
    import sched_pkg::*;
#(
    parameter int unsigned NUM_PARALLEL_INSTANCES = SCHED_NUM_INST,
    parameter int unsigned MAX_DEPENDENCIES       = SCHED_MAX_DEPS,
    parameter int unsigned MAX_BATCH_SIZE         = 8,
    parameter int unsigned MAX_OUTSTANDING        = 2,
    parameter int unsigned IDX_W                  = $clog2(NUM_PARALLEL_INSTANCES)
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [NUM_PARALLEL_INSTANCES-1:0]              s_tvalid,
    output logic [NUM_PARALLEL_INSTANCES-1:0]              s_tready,
    input  logic [NUM_PARALLEL_INSTANCES-1:0]              s_tlast,
    input  logic [NUM_PARALLEL_INSTANCES*OWNER_W-1:0]      s_owner_id,
    input  logic [NUM_PARALLEL_INSTANCES*MAX_DEPENDENCIES-1:0] s_read_deps,
    input  logic [NUM_PARALLEL_INSTANCES*MAX_DEPENDENCIES-1:0] s_write_deps,
    output logic                                           m_tvalid,
    input  logic                                           m_tready,
    output logic                                           m_tlast,
    output logic [IDX_W-1:0]                               m_tdest,
    output logic [OWNER_W-1:0]                             m_owner_id,
    output logic [MAX_DEPENDENCIES-1:0]                    m_read_deps,
    output logic [MAX_DEPENDENCIES-1:0]                    m_write_deps,
    input  logic                                           done_valid,
    input  logic [IDX_W-1:0]                               done_id,
    output logic [NUM_PARALLEL_INSTANCES-1:0]              batch_retire,
    output logic [NUM_PARALLEL_INSTANCES*OCNT_W-1:0]       outstanding_count,
    output logic [STAT_W-1:0]                              dispatched_batches,
    output logic [STAT_W-1:0]                              forced_terminations,
    output logic [STAT_W-1:0]                              retire_errors
);

    localparam int unsigned N    = NUM_PARALLEL_INSTANCES;
    localparam int unsigned BC_W = $clog2(MAX_BATCH_SIZE + 1);

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]  grant_idx_q, grant_idx_d;
    logic [BC_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [OCNT_W-1:0] outst_q [N];
    logic [OCNT_W-1:0] outst_d [N];
    logic [N-1:0]      retire_q, retire_d;
    logic [STAT_W-1:0] dispatched_q, dispatched_d;
    logic [STAT_W-1:0] forced_q, forced_d;
    logic [STAT_W-1:0] rerr_q, rerr_d;

    logic [N-1:0]      eligible;
    logic              pick_valid;
    logic [IDX_W-1:0]  pick_idx;
    logic              hs;
    logic              batch_end;
    logic              done_in_range;
    logic              done_nz;
    logic              ret_ok;

    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < N; i++) begin
            eligible[i] = s_tvalid[i] && (outst_q[i] < OCNT_W'(MAX_OUTSTANDING));
        end
    end

    rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req       (eligible),
        .ptr       (rr_ptr_q),
        .gnt_valid (pick_valid),
        .gnt_idx   (pick_idx)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_valid) state_d = BURST;
            BURST:   if (batch_end)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: grant channel muxed onto the executor port only while bursting
    always_comb begin
        m_tvalid     = 1'b0;
        m_tlast      = 1'b0;
        m_tdest      = '0;
        m_owner_id   = '0;
        m_read_deps  = '0;
        m_write_deps = '0;
        s_tready     = '0;
        if (state_q == BURST) begin
            m_tvalid     = s_tvalid[grant_idx_q];
            m_tlast      = s_tlast[grant_idx_q] ||
                           (beat_cnt_q == BC_W'(MAX_BATCH_SIZE - 1));
            m_tdest      = grant_idx_q;
            m_owner_id   = s_owner_id[32'(grant_idx_q)*OWNER_W +: OWNER_W];
            m_read_deps  = s_read_deps[32'(grant_idx_q)*MAX_DEPENDENCIES +: MAX_DEPENDENCIES];
            m_write_deps = s_write_deps[32'(grant_idx_q)*MAX_DEPENDENCIES +: MAX_DEPENDENCIES];
            s_tready[grant_idx_q] = m_tready;
        end
    end

    assign hs        = m_tvalid && m_tready;
    assign batch_end = hs && m_tlast;

    // Retire validity is judged on the pre-update count, so a same-cycle dispatch cannot mask it
    always_comb begin
        done_in_range = 1'b0;
        done_nz       = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (done_id == IDX_W'(i)) begin
                done_in_range = 1'b1;
                done_nz       = (outst_q[i] != '0);
            end
        end
        ret_ok = done_valid && done_in_range && done_nz;
    end

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        grant_idx_d  = grant_idx_q;
        beat_cnt_d   = beat_cnt_q;
        dispatched_d = dispatched_q;
        forced_d     = forced_q;
        rerr_d       = rerr_q;
        retire_d     = '0;

        if (state_q == IDLE && pick_valid) begin
            grant_idx_d = pick_idx;
            beat_cnt_d  = '0;
        end
        if (hs) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
        end
        if (batch_end) begin
            dispatched_d = dispatched_q + 32'd1;
            rr_ptr_d     = (32'(grant_idx_q) == N - 1) ? '0 : grant_idx_q + 1'b1;
            if (!s_tlast[grant_idx_q]) begin
                forced_d = forced_q + 32'd1;
            end
        end
        if (done_valid && !ret_ok) begin
            rerr_d = rerr_q + 32'd1;
        end

        for (int unsigned i = 0; i < N; i++) begin
            outst_d[i]  = outst_q[i];
            retire_d[i] = ret_ok && (done_id == IDX_W'(i));
            if (batch_end && (grant_idx_q == IDX_W'(i)) && !retire_d[i]) begin
                outst_d[i] = outst_q[i] + 1'b1;
            end else if (retire_d[i] && !(batch_end && (grant_idx_q == IDX_W'(i)))) begin
                outst_d[i] = outst_q[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            grant_idx_q  <= '0;
            beat_cnt_q   <= '0;
            retire_q     <= '0;
            dispatched_q <= '0;
            forced_q     <= '0;
            rerr_q       <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                outst_q[i] <= '0;
            end
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            grant_idx_q  <= grant_idx_d;
            beat_cnt_q   <= beat_cnt_d;
            retire_q     <= retire_d;
            dispatched_q <= dispatched_d;
            forced_q     <= forced_d;
            rerr_q       <= rerr_d;
            for (int unsigned i = 0; i < N; i++) begin
                outst_q[i] <= outst_d[i];
            end
        end
    end

    always_comb begin
        outstanding_count = '0;
        for (int unsigned i = 0; i < N; i++) begin
            outstanding_count[i*OCNT_W +: OCNT_W] = outst_q[i];
        end
    end

    assign batch_retire        = retire_q;
    assign dispatched_batches  = dispatched_q;
    assign forced_terminations = forced_q;
    assign retire_errors       = rerr_q;

endmodule

// File: tb/tb_batch_dispatch_arbiter.sv
// Directed bench for batch_dispatch_arbiter: queued source model, beat log monitor, fixed expectations.
module tb_batch_dispatch_arbiter;

    localparam int N    = 4;
    localparam int DEPS = 256;

    logic                clk = 1'b0;
    logic                rst;
    logic [N-1:0]        s_tvalid, s_tready, s_tlast;
    logic [N*64-1:0]     s_owner_id;
    logic [N*DEPS-1:0]   s_read_deps, s_write_deps;
    logic                m_tvalid, m_tready, m_tlast;
    logic [1:0]          m_tdest;
    logic [63:0]         m_owner_id;
    logic [DEPS-1:0]     m_read_deps, m_write_deps;
    logic                done_valid;
    logic [1:0]          done_id;
    logic [N-1:0]        batch_retire;
    logic [N*4-1:0]      outstanding_count;
    logic [31:0]         dispatched_batches, forced_terminations, retire_errors;

    batch_dispatch_arbiter #(
        .NUM_PARALLEL_INSTANCES (4),
        .MAX_DEPENDENCIES       (256),
        .MAX_BATCH_SIZE         (8),
        .MAX_OUTSTANDING        (2),
        .IDX_W                  (2)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .s_tvalid            (s_tvalid),
        .s_tready            (s_tready),
        .s_tlast             (s_tlast),
        .s_owner_id          (s_owner_id),
        .s_read_deps         (s_read_deps),
        .s_write_deps        (s_write_deps),
        .m_tvalid            (m_tvalid),
        .m_tready            (m_tready),
        .m_tlast             (m_tlast),
        .m_tdest             (m_tdest),
        .m_owner_id          (m_owner_id),
        .m_read_deps         (m_read_deps),
        .m_write_deps        (m_write_deps),
        .done_valid          (done_valid),
        .done_id             (done_id),
        .batch_retire        (batch_retire),
        .outstanding_count   (outstanding_count),
        .dispatched_batches  (dispatched_batches),
        .forced_terminations (forced_terminations),
        .retire_errors       (retire_errors)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] owner;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic [1:0]  dest;
        logic        last;
        logic        deps_ok;
        logic [15:0] owner;
    } obs_t;

    beat_t srcq [N][$];
    obs_t  log_q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ob(input logic [1:0] dest, input logic [15:0] owner,
                                       input logic last);
        obs_t o;
        o.dest    = dest;
        o.last    = last;
        o.deps_ok = 1'b1;
        o.owner   = owner;
        return 64'(o);
    endfunction

    task automatic check_log(input int idx, input logic [1:0] dest, input logic [15:0] owner,
                             input logic last);
        logic [63:0] got;
        got = (idx < log_q.size()) ? 64'(log_q[idx]) : '1;
        check($sformatf("beat%0d", idx), got, ob(dest, owner, last));
    endtask

    task automatic drive_srcs();
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() > 0) begin
                s_tvalid[i]                 = 1'b1;
                s_tlast[i]                  = srcq[i][0].last;
                s_owner_id[i*64 +: 64]      = srcq[i][0].owner;
                s_read_deps[i*DEPS +: DEPS] = {192'b0, srcq[i][0].owner};
                s_write_deps[i*DEPS +: DEPS] = ~{192'b0, srcq[i][0].owner};
            end else begin
                s_tvalid[i] = 1'b0;
                s_tlast[i]  = 1'b0;
            end
        end
    endtask

    task automatic push_batch(input int inst, input int seq, input int n, input bit has_last);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.owner = 64'(inst * 256 + seq + k);
            b.last  = has_last && (k == n - 1);
            srcq[inst].push_back(b);
        end
        drive_srcs();
    endtask

    task automatic wait_cycles(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic do_retire(input logic [1:0] id, input logic [3:0] exp_pulse);
        done_valid = 1'b1;
        done_id    = id;
        @(negedge clk);
        done_valid = 1'b0;
        check("retire_pulse", 64'(batch_retire), 64'(exp_pulse));
        @(negedge clk);
        check("retire_clear", 64'(batch_retire), 64'd0);
    endtask

    // Source pops and beat logging both use values settled before the edge
    always @(posedge clk) begin
        obs_t o;
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                if (s_tvalid[i] && s_tready[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
            end
        end
        if (m_tvalid && m_tready && !rst) begin
            o.dest    = m_tdest;
            o.last    = m_tlast;
            o.deps_ok = (m_read_deps == {192'b0, m_owner_id}) &&
                        (m_write_deps == ~{192'b0, m_owner_id});
            o.owner   = m_owner_id[15:0];
            log_q.push_back(o);
        end
        #1 drive_srcs();
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int w;
        rst          = 1'b1;
        s_tvalid     = '0;
        s_tlast      = '0;
        s_owner_id   = '0;
        s_read_deps  = '0;
        s_write_deps = '0;
        m_tready     = 1'b0;
        done_valid   = 1'b0;
        done_id      = '0;
        wait_cycles(3);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_s_tready", 64'(s_tready), 64'd0);
        check("rst_outstanding", 64'(outstanding_count), 64'd0);
        check("rst_dispatched", 64'(dispatched_batches), 64'd0);
        check("rst_forced", 64'(forced_terminations), 64'd0);
        check("rst_rerr", 64'(retire_errors), 64'd0);
        check("rst_retire", 64'(batch_retire), 64'd0);

        // Two 3-beat batches from inst0 and inst2
        m_tready = 1'b1;
        push_batch(0, 'h00, 3, 1'b1);
        push_batch(2, 'h00, 3, 1'b1);
        wait_cycles(12);
        check("t1_len", 64'(log_q.size()), 64'd6);
        check_log(0, 2'd0, 16'h000, 1'b0);
        check_log(1, 2'd0, 16'h001, 1'b0);
        check_log(2, 2'd0, 16'h002, 1'b1);
        check_log(3, 2'd2, 16'h200, 1'b0);
        check_log(4, 2'd2, 16'h201, 1'b0);
        check_log(5, 2'd2, 16'h202, 1'b1);
        check("t1_dispatched", 64'(dispatched_batches), 64'd2);
        check("t1_outstanding", 64'(outstanding_count), 64'h0101);
        do_retire(2'd0, 4'b0001);
        do_retire(2'd2, 4'b0100);
        check("t1_outst_clean", 64'(outstanding_count), 64'h0);

        // Throttle at MAX_OUTSTANDING
        log_q.delete();
        push_batch(1, 'h00, 1, 1'b1);
        push_batch(1, 'h01, 1, 1'b1);
        push_batch(1, 'h02, 1, 1'b1);
        wait_cycles(10);
        check("t2_len", 64'(log_q.size()), 64'd2);
        check("t2_s_tready", 64'(s_tready), 64'd0);
        check("t2_m_tvalid", 64'(m_tvalid), 64'd0);
        check("t2_pending", 64'(srcq[1].size()), 64'd1);
        check("t2_outstanding", 64'(outstanding_count), 64'h0020);
        do_retire(2'd1, 4'b0010);
        wait_cycles(4);
        check("t2_len_after", 64'(log_q.size()), 64'd3);
        check_log(0, 2'd1, 16'h100, 1'b1);
        check_log(1, 2'd1, 16'h101, 1'b1);
        check_log(2, 2'd1, 16'h102, 1'b1);
        check("t2_outstanding2", 64'(outstanding_count), 64'h0020);
        check("t2_dispatched", 64'(dispatched_batches), 64'd5);
        do_retire(2'd1, 4'b0010);
        do_retire(2'd1, 4'b0010);

        // Forced termination at MAX_BATCH_SIZE
        log_q.delete();
        push_batch(3, 'h00, 10, 1'b0);
        wait_cycles(16);
        check("t3_len", 64'(log_q.size()), 64'd10);
        for (int k = 0; k < 10; k++) check_log(k, 2'd3, 16'(16'h300 + k), (k == 7));
        check("t3_forced", 64'(forced_terminations), 64'd1);
        check("t3_hold_tvalid", 64'(m_tvalid), 64'd0);
        check("t3_hold_tready", 64'(s_tready), 64'b1000);
        push_batch(3, 'h0a, 1, 1'b1);
        wait_cycles(3);
        check_log(10, 2'd3, 16'h30a, 1'b1);
        check("t3_forced2", 64'(forced_terminations), 64'd1);
        check("t3_dispatched", 64'(dispatched_batches), 64'd7);
        check("t3_outstanding", 64'(outstanding_count), 64'h2000);
        do_retire(2'd3, 4'b1000);
        do_retire(2'd3, 4'b1000);

        // Backpressure and fairness
        log_q.delete();
        push_batch(0, 'h20, 2, 1'b1);
        push_batch(0, 'h22, 2, 1'b1);
        push_batch(1, 'h20, 2, 1'b1);
        push_batch(2, 'h20, 2, 1'b1);
        push_batch(3, 'h20, 2, 1'b1);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            m_tready = ~m_tready;
        end
        m_tready = 1'b1;
        wait_cycles(2);
        check("t4_len", 64'(log_q.size()), 64'd10);
        check_log(0, 2'd0, 16'h020, 1'b0);
        check_log(1, 2'd0, 16'h021, 1'b1);
        check_log(2, 2'd1, 16'h120, 1'b0);
        check_log(3, 2'd1, 16'h121, 1'b1);
        check_log(4, 2'd2, 16'h220, 1'b0);
        check_log(5, 2'd2, 16'h221, 1'b1);
        check_log(6, 2'd3, 16'h320, 1'b0);
        check_log(7, 2'd3, 16'h321, 1'b1);
        check_log(8, 2'd0, 16'h022, 1'b0);
        check_log(9, 2'd0, 16'h023, 1'b1);
        check("t4_dispatched", 64'(dispatched_batches), 64'd12);
        check("t4_outstanding", 64'(outstanding_count), 64'h1112);
        do_retire(2'd0, 4'b0001);
        do_retire(2'd1, 4'b0010);
        do_retire(2'd2, 4'b0100);
        do_retire(2'd3, 4'b1000);
        check("t4_outst_left", 64'(outstanding_count), 64'h0001);

        // Same-cycle dispatch and retire on inst0, then a bad retire
        log_q.delete();
        push_batch(0, 'h50, 1, 1'b1);
        @(negedge clk);
        check("t5_burst", 64'({m_tvalid, m_tlast, m_tdest}), 64'b1100);
        done_valid = 1'b1;
        done_id    = 2'd0;
        @(negedge clk);
        done_valid = 1'b0;
        check("t5_pulse", 64'(batch_retire), 64'b0001);
        check("t5_outstanding", 64'(outstanding_count), 64'h0001);
        check("t5_dispatched", 64'(dispatched_batches), 64'd13);
        @(negedge clk);
        check("t5_pulse_clear", 64'(batch_retire), 64'd0);
        do_retire(2'd3, 4'b0000);
        check("t5_rerr", 64'(retire_errors), 64'd1);
        check("t5_outst_same", 64'(outstanding_count), 64'h0001);

        // Reset mid-burst
        log_q.delete();
        push_batch(0, 'h60, 4, 1'b1);
        w = 0;
        while (log_q.size() < 2 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("t6_two_beats", 64'(log_q.size() >= 2), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < N; i++) srcq[i].delete();
        drive_srcs();
        check("t6_s_tready", 64'(s_tready), 64'd0);
        check("t6_m_tvalid", 64'(m_tvalid), 64'd0);
        check("t6_outstanding", 64'(outstanding_count), 64'd0);
        check("t6_counters", {dispatched_batches, forced_terminations}, 64'd0);
        check("t6_rerr", 64'(retire_errors), 64'd0);
        rst = 1'b0;
        log_q.delete();
        push_batch(2, 'h70, 1, 1'b1);
        wait_cycles(4);
        check_log(0, 2'd2, 16'h270, 1'b1);
        check("t6_dispatched", 64'(dispatched_batches), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
